// File: rtl/name_scan_ctrl_if.sv
// Bus bundle for the name-initial display scanner: scan enable,
// code-load handshake and the multiplexed display drive.
interface name_scan_ctrl_if;
  logic       en;
  logic       load_valid;
  logic [5:0] load_codes;
  logic       load_ready;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_tick;

  modport master (
    output en, load_valid, load_codes,
    input  load_ready, seg, an, frame_tick
  );

  modport slave (
    input  en, load_valid, load_codes,
    output load_ready, seg, an, frame_tick
  );
endinterface

// File: rtl/name_scan_ctrl.sv
// Three-digit time-multiplexed 7-segment scanner for the name initials.
// New codes are held in a shadow register and only become visible at a
// frame boundary, so a frame never mixes old and new characters.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_OFF   | scanning disabled, cnt/digit parked at 0, display dark
// S_BLANK | first BLANK_CYCLES of a digit slot, all digits off (guard)
// S_SHOW  | rest of the slot, current digit lit with its decoded code
module name_scan_ctrl #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  name_scan_ctrl_if.slave bus
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST      = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  typedef enum logic [1:0] {S_OFF, S_BLANK, S_SHOW} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    digit, digit_n;
  logic          tick_q, tick_n;
  logic [5:0]    codes;
  logic [5:0]    shadow;
  logic          pending;
  logic          take;
  logic          apply;
  logic [1:0]    cur_code;

  // A boundary edge applies the shadow; with scanning off it is applied at once.
  assign take  = bus.load_valid && !pending;
  assign apply = pending && (tick_q || !bus.en);

  // Scan state, slot counter, digit index and the boundary flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_OFF;
      cnt    <= '0;
      digit  <= 2'd0;
      tick_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      digit  <= digit_n;
      tick_q <= tick_n;
    end
  end

  // Next slot position; wrapping out of digit 2 marks the next cycle as a boundary.
  always_comb begin
    cnt_n   = cnt;
    digit_n = digit;
    tick_n  = 1'b0;
    state_n = state;
    if (!bus.en) begin
      cnt_n   = '0;
      digit_n = 2'd0;
      state_n = S_OFF;
    end else begin
      if (cnt == LAST) begin
        cnt_n = '0;
        if (digit == 2'd2) begin
          digit_n = 2'd0;
          tick_n  = 1'b1;
        end else begin
          digit_n = digit + 2'd1;
        end
      end else begin
        cnt_n = cnt + 1'b1;
      end
      state_n = (cnt_n < BLANK_END) ? S_BLANK : S_SHOW;
    end
  end

  // Load handshake: shadow capture on transfer, displayed codes swap on apply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      codes   <= 6'h3F;
      shadow  <= 6'h00;
      pending <= 1'b0;
    end else begin
      if (take) begin
        shadow  <= bus.load_codes;
        pending <= 1'b1;
      end else if (apply) begin
        codes   <= shadow;
        pending <= 1'b0;
      end
    end
  end

  // Code of the digit currently being scanned.
  always_comb begin
    case (digit)
      2'd0:    cur_code = codes[1:0];
      2'd1:    cur_code = codes[3:2];
      default: cur_code = codes[5:4];
    endcase
  end

  // Display drive: dark unless in the SHOW phase with scanning enabled.
  always_comb begin
    bus.seg = 7'b1111111;
    bus.an  = 3'b111;
    if (bus.en && state == S_SHOW) begin
      case (digit)
        2'd0:    bus.an = 3'b110;
        2'd1:    bus.an = 3'b101;
        default: bus.an = 3'b011;
      endcase
      case (cur_code)
        2'd0:    bus.seg = 7'b0111000;
        2'd1:    bus.seg = 7'b0000000;
        2'd2:    bus.seg = 7'b0001000;
        default: bus.seg = 7'b1111111;
      endcase
    end
  end

  assign bus.load_ready = ~pending;
  assign bus.frame_tick = tick_q;

endmodule
